// File: rtl/aes_pkg.sv
// Shared definitions for the AES host command sequencer.
// Contents:
//   aes_state_t       sequencer states
//   AES_ENC/AES_DEC   cmd_mode / aes_ctrl[1:0] encodings (1x is reserved)
//   AES_CTRL_RUN_BIT  aes_ctrl bit that hands memory and run control to the engine
//   address map and sizing defaults, mode_is_reserved() helper
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_DATA,
    RUN,
    WAIT,
    READ,
    DRAIN
  } aes_state_t;

  localparam logic [1:0] AES_ENC = 2'b00;
  localparam logic [1:0] AES_DEC = 2'b01;

  localparam int unsigned AES_CTRL_RUN_BIT = 2;

  localparam logic [9:0] AES_KEY_BASE = 10'd0;
  localparam logic [9:0] AES_IN_BASE  = 10'd16;
  localparam logic [9:0] AES_OUT_BASE = 10'd32;

  localparam int unsigned AES_KEY_WORDS   = 4;
  localparam int unsigned AES_BLOCK_WORDS = 4;
  localparam int unsigned AES_RD_LATENCY  = 2;
  localparam int unsigned AES_TIMEOUT     = 4096;

  function automatic logic mode_is_reserved(input logic [1:0] mode);
    return (mode != AES_ENC) && (mode != AES_DEC);
  endfunction

endpackage

// File: rtl/aes_rd_buffer.sv
// Result read-back buffer for the AES host sequencer.
// A tag pipeline of RD_LATENCY stages follows each issued read so the word
// returning on rd_data lands in the right slot of a BLOCK_WORDS buffer.
// While drain_en is high the buffer is emitted in order on a valid/ready port.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   issue_valid     a read is presented to AES memory this cycle
//   issue_idx       word index of that read
//   rd_data         AES memory read data (RD_LATENCY after the address)
//   drain_en        sequencer is in DRAIN
//   out_ready       consumer ready
//   landed_last     final word of the block is being captured this cycle
//   out_valid/out_data/out_last  result stream
//   drain_done      handshake of the final word this cycle
module aes_rd_buffer
  import aes_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS = AES_BLOCK_WORDS,
  parameter int unsigned RD_LATENCY  = AES_RD_LATENCY,
  localparam int unsigned IW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  input  logic [IW-1:0] issue_idx,
  input  logic [31:0]   rd_data,
  input  logic          drain_en,
  input  logic          out_ready,
  output logic          landed_last,
  output logic          out_valid,
  output logic [31:0]   out_data,
  output logic          out_last,
  output logic          drain_done
);

  localparam logic [IW-1:0] LAST_IDX = IW'(BLOCK_WORDS - 1);

  logic [RD_LATENCY-1:0] tag_vld;
  logic [IW-1:0]         tag_idx [RD_LATENCY];
  logic [31:0]           buf_q   [BLOCK_WORDS];
  logic [IW-1:0]         rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) tag_idx[i] <= '0;
      for (int unsigned i = 0; i < BLOCK_WORDS; i++) buf_q[i] <= '0;
      rd_ptr <= '0;
    end else begin
      tag_vld[0] <= issue_valid;
      tag_idx[0] <= issue_idx;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
      if (tag_vld[RD_LATENCY-1]) buf_q[tag_idx[RD_LATENCY-1]] <= rd_data;
      if (drain_en && out_ready) rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Reads return in issue order, so the last index arriving means the block is complete.
  assign landed_last = tag_vld[RD_LATENCY-1] && (tag_idx[RD_LATENCY-1] == LAST_IDX);
  assign out_valid   = drain_en;
  assign out_data    = drain_en ? buf_q[rd_ptr] : '0;
  assign out_last    = drain_en && (rd_ptr == LAST_IDX);
  assign drain_done  = drain_en && out_ready && (rd_ptr == LAST_IDX);

endmodule

// File: rtl/aes_host_seq.sv
// AES host command sequencer: accepts a command and a word stream (optional
// key, then one block), writes it into AES memory, runs the engine, reads the
// result block back and returns it as a valid/ready word stream.
// Ports:
//   clk_in, rst_in                    clock, asynchronous active-high reset
//   cmd_valid_in/cmd_ready_out        command handshake; cmd_mode_in, cmd_load_key_in
//   in_valid_in/in_ready_out          input word handshake; in_data_in
//   out_valid_out/out_ready_in        result handshake; out_data_out, out_last_out
//   busy_out                          not IDLE
//   error_out                         reserved mode or timeout, sticky to next command
//   aes_ctrl_out                      [2] engine owns memory/run, [1:0] mode
//   aes_data_out, aes_mem_we_out, aes_mem_wr_addr_out   host write port
//   aes_mem_rd_addr_out, aes_data_in  host read port
//   aes_complete_in                   engine done
module aes_host_seq
  import aes_pkg::*;
#(
  parameter int unsigned KEY_WORDS   = AES_KEY_WORDS,
  parameter int unsigned BLOCK_WORDS = AES_BLOCK_WORDS,
  parameter logic [9:0]  KEY_BASE    = AES_KEY_BASE,
  parameter logic [9:0]  IN_BASE     = AES_IN_BASE,
  parameter logic [9:0]  OUT_BASE    = AES_OUT_BASE,
  parameter int unsigned RD_LATENCY  = AES_RD_LATENCY,
  parameter int unsigned TIMEOUT     = AES_TIMEOUT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic [1:0]  cmd_mode_in,
  input  logic        cmd_load_key_in,
  input  logic        in_valid_in,
  output logic        in_ready_out,
  input  logic [31:0] in_data_in,
  output logic        out_valid_out,
  input  logic        out_ready_in,
  output logic [31:0] out_data_out,
  output logic        out_last_out,
  output logic        busy_out,
  output logic        error_out,
  output logic [2:0]  aes_ctrl_out,
  output logic [31:0] aes_data_out,
  output logic [3:0]  aes_mem_we_out,
  output logic [9:0]  aes_mem_rd_addr_out,
  output logic [9:0]  aes_mem_wr_addr_out,
  input  logic [31:0] aes_data_in,
  input  logic        aes_complete_in
);

  localparam int unsigned MAX_WORDS = (KEY_WORDS > BLOCK_WORDS) ? KEY_WORDS : BLOCK_WORDS;
  localparam int unsigned CW = $clog2(MAX_WORDS + 1);
  localparam int unsigned IW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] KEY_LAST  = CW'(KEY_WORDS - 1);
  localparam logic [CW-1:0] BLK_LAST  = CW'(BLOCK_WORDS - 1);
  localparam logic [CW-1:0] RD_END    = CW'(BLOCK_WORDS);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  aes_state_t    state;
  logic [1:0]    mode_q;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] rd_cnt;
  logic [TW-1:0] wait_cnt;
  logic [2:0]    ctrl_q;
  logic          error_q;

  logic          cmd_fire;
  logic          load_state;
  logic          wr_beat;
  logic          issuing;
  logic          landed_last;
  logic          drain_done;

  assign cmd_fire   = (state == IDLE) && cmd_valid_in;
  assign load_state = (state == LOAD_KEY) || (state == LOAD_DATA);
  assign wr_beat    = load_state && in_valid_in;
  assign issuing    = (state == READ) && (rd_cnt != RD_END);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      mode_q   <= AES_ENC;
      wcnt     <= '0;
      rd_cnt   <= '0;
      wait_cnt <= '0;
      ctrl_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            mode_q <= cmd_mode_in;
            wcnt   <= '0;
            if (mode_is_reserved(cmd_mode_in)) begin
              error_q <= 1'b1;
            end else begin
              error_q <= 1'b0;
              state   <= cmd_load_key_in ? LOAD_KEY : LOAD_DATA;
            end
          end
        end
        LOAD_KEY: begin
          if (wr_beat) begin
            if (wcnt == KEY_LAST) begin
              wcnt  <= '0;
              state <= LOAD_DATA;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        LOAD_DATA: begin
          if (wr_beat) begin
            if (wcnt == BLK_LAST) begin
              wcnt  <= '0;
              state <= RUN;
              // Engine takes ownership as RUN begins, so ctrl is valid for the whole RUN cycle.
              ctrl_q                   <= '0;
              ctrl_q[AES_CTRL_RUN_BIT] <= 1'b1;
              ctrl_q[1:0]              <= mode_q;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        RUN: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // Completion is checked first so it wins over a same-cycle timeout.
          if (aes_complete_in) begin
            ctrl_q <= '0;
            rd_cnt <= '0;
            state  <= READ;
          end else if (wait_cnt == WAIT_LAST) begin
            ctrl_q  <= '0;
            error_q <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        READ: begin
          if (issuing) rd_cnt <= rd_cnt + 1'b1;
          if (landed_last) state <= DRAIN;
        end
        DRAIN: begin
          if (drain_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  aes_rd_buffer #(
    .BLOCK_WORDS (BLOCK_WORDS),
    .RD_LATENCY  (RD_LATENCY)
  ) u_rd_buffer (
    .clk         (clk_in),
    .rst         (rst_in),
    .issue_valid (issuing),
    .issue_idx   (rd_cnt[IW-1:0]),
    .rd_data     (aes_data_in),
    .drain_en    (state == DRAIN),
    .out_ready   (out_ready_in),
    .landed_last (landed_last),
    .out_valid   (out_valid_out),
    .out_data    (out_data_out),
    .out_last    (out_last_out),
    .drain_done  (drain_done)
  );

  assign cmd_ready_out       = (state == IDLE);
  assign in_ready_out        = load_state;
  assign busy_out            = (state != IDLE);
  assign error_out           = error_q;
  assign aes_ctrl_out        = ctrl_q;
  // Accepted words go straight to memory in the same cycle they are handshaken.
  assign aes_mem_we_out      = wr_beat ? 4'hF : '0;
  assign aes_data_out        = wr_beat ? in_data_in : '0;
  assign aes_mem_wr_addr_out = wr_beat ? (((state == LOAD_KEY) ? KEY_BASE : IN_BASE) + 10'(wcnt)) : '0;
  assign aes_mem_rd_addr_out = issuing ? (OUT_BASE + 10'(rd_cnt)) : '0;

endmodule

// File: tb/tb_aes_host_seq.sv
module tb_aes_host_seq;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam int TIMEOUT = 4096;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_load_key;
  logic [1:0]  cmd_mode;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic        busy, error;
  logic [2:0]  aes_ctrl;
  logic [31:0] aes_wdata, aes_rdata;
  logic [3:0]  aes_we;
  logic [9:0]  rd_addr, wr_addr;
  logic        aes_complete = 1'b0;

  int errors = 0, checks = 0, viol = 0, stab_viol = 0;

  logic [31:0] mem [1024];
  logic [31:0] rd_p1, rd_p2;
  int          eng_cnt = 0;
  int          eng_lat = 3;
  bit          eng_never = 0;
  logic [1:0]  cur_mode = 2'b00;
  logic [127:0] ref_key;

  logic [41:0] wr_log [$];
  logic [31:0] got_q [$];
  bit          last_q [$];

  typedef struct {
    logic [1:0]   mode;
    bit           lk;
    logic [127:0] key;
    logic [127:0] blk;
    logic [127:0] exp;
  } vec_t;
  vec_t vt [4];

  aes_host_seq dut (
    .clk_in              (clk),
    .rst_in              (rst),
    .cmd_valid_in        (cmd_valid),
    .cmd_ready_out       (cmd_ready),
    .cmd_mode_in         (cmd_mode),
    .cmd_load_key_in     (cmd_load_key),
    .in_valid_in         (in_valid),
    .in_ready_out        (in_ready),
    .in_data_in          (in_data),
    .out_valid_out       (out_valid),
    .out_ready_in        (out_ready),
    .out_data_out        (out_data),
    .out_last_out        (out_last),
    .busy_out            (busy),
    .error_out           (error),
    .aes_ctrl_out        (aes_ctrl),
    .aes_data_out        (aes_wdata),
    .aes_mem_we_out      (aes_we),
    .aes_mem_rd_addr_out (rd_addr),
    .aes_mem_wr_addr_out (wr_addr),
    .aes_data_in         (aes_rdata),
    .aes_complete_in     (aes_complete)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in cipher: real FIPS-197 answers for the reference vectors, an
  // invertible word-wise mix for everything else.
  function automatic logic [127:0] cipher(input logic [1:0] m, input logic [127:0] k, input logic [127:0] b);
    logic [127:0] r;
    if (k == FIPS_KEY && m == 2'b00 && b == FIPS_PT) return FIPS_CT;
    if (k == FIPS_KEY && m == 2'b01 && b == FIPS_CT) return FIPS_PT;
    for (int i = 0; i < 4; i++) begin
      if (m == 2'b00) r[127-32*i -: 32] = (b[127-32*i -: 32] ^ k[127-32*i -: 32]) + 32'h9e3779b9;
      else            r[127-32*i -: 32] = (b[127-32*i -: 32] - 32'h9e3779b9) ^ k[127-32*i -: 32];
    end
    return r;
  endfunction

  // AES memory with 2-cycle read latency plus a simple engine model.
  always @(posedge clk) begin : mem_eng
    logic [127:0] r;
    if (aes_we != 4'h0) mem[wr_addr] <= aes_wdata;
    rd_p1 <= mem[rd_addr];
    rd_p2 <= rd_p1;
    if (aes_ctrl[2]) begin
      eng_cnt      <= eng_cnt + 1;
      aes_complete <= 1'b0;
      if (eng_cnt == eng_lat && !eng_never) begin
        r = cipher(aes_ctrl[1:0], {mem[0], mem[1], mem[2], mem[3]}, {mem[16], mem[17], mem[18], mem[19]});
        for (int i = 0; i < 4; i++) mem[32+i] <= r[127-32*i -: 32];
        aes_complete <= 1'b1;
      end
    end else begin
      eng_cnt      <= 0;
      aes_complete <= 1'b0;
    end
  end
  assign aes_rdata = rd_p2;

  // Write-port monitor and ownership invariants.
  always @(negedge clk) begin
    if (!rst) begin
      if (aes_we != 4'h0) begin
        wr_log.push_back({wr_addr, aes_wdata});
        if (aes_ctrl[2]) viol++;
        if (!in_valid || !in_ready) viol++;
        if (aes_we != 4'hF) viol++;
      end
      if (aes_ctrl[2] && aes_ctrl[1:0] != cur_mode) viol++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] mode, input bit lk, output bit ok);
    cmd_valid = 1'b1; cmd_mode = mode; cmd_load_key = lk; ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      ok = cmd_ready;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_pct, output bit ok);
    while ($urandom_range(99) < gap_pct) begin
      in_data = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b1; in_data = w; ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      ok = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int rdy_pct);
    bit pv = 0, pr = 0;
    logic [31:0] pd = '0;
    got_q.delete(); last_q.delete();
    for (int cyc = 0; cyc < 2000 && got_q.size() < 4; cyc++) begin
      if (pv && !pr && !(out_valid && out_data == pd)) stab_viol++;
      out_ready = ($urandom_range(99) < rdy_pct);
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        last_q.push_back(out_last);
      end
      pv = out_valid; pr = out_ready; pd = out_data;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic run_txn(input string tag, input logic [1:0] mode, input bit lk, input logic [127:0] key,
                         input logic [127:0] blk, input logic [127:0] exp, input int gap_pct,
                         input int rdy_pct, input int lat);
    bit ok;
    logic [41:0] ew [$];
    eng_lat = lat; cur_mode = mode; wr_log.delete();
    send_cmd(mode, lk, ok);
    chk({tag, " cmd_accept"}, 32'(ok), 32'd1);
    chk({tag, " error_cleared"}, 32'(error), 32'd0);
    if (lk) for (int i = 0; i < 4; i++) begin
      send_word(key[127-32*i -: 32], gap_pct, ok);
      if (!ok) chk({tag, " key_accept"}, 32'(ok), 32'd1);
      ew.push_back({10'(i), key[127-32*i -: 32]});
    end
    for (int i = 0; i < 4; i++) begin
      send_word(blk[127-32*i -: 32], gap_pct, ok);
      if (!ok) chk({tag, " blk_accept"}, 32'(ok), 32'd1);
      ew.push_back({10'(16 + i), blk[127-32*i -: 32]});
    end
    collect(rdy_pct);
    chk({tag, " out_count"}, 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      chk($sformatf("%s word%0d", tag, i), got_q[i], exp[127-32*i -: 32]);
      chk($sformatf("%s last%0d", tag, i), 32'(last_q[i]), 32'(i == 3));
    end
    chk({tag, " cmd_ready_after"}, 32'(cmd_ready), 32'd1);
    chk({tag, " no_extra_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " write_count"}, 32'(wr_log.size()), 32'(ew.size()));
    for (int i = 0; i < ew.size() && i < wr_log.size(); i++)
      chk($sformatf("%s write%0d", tag, i), 32'(wr_log[i] != ew[i]), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " ctrl"}, 32'(aes_ctrl), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " out_data"}, out_data, 32'd0);
    chk({tag, " we"}, 32'(aes_we), 32'd0);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, " error"}, 32'(error), 32'd0);
  endtask

  initial begin : main
    bit ok;
    int hi, ov;
    logic [127:0] blk, key;
    logic [1:0] m;
    bit lk;

    rst = 1'b1; cmd_valid = 0; cmd_mode = 0; cmd_load_key = 0;
    in_valid = 0; in_data = 0; out_ready = 0;
    ref_key = '0;

    vt[0] = '{mode: 2'b00, lk: 1, key: FIPS_KEY, blk: FIPS_PT, exp: FIPS_CT};
    vt[1] = '{mode: 2'b01, lk: 0, key: '0,       blk: FIPS_CT, exp: FIPS_PT};
    vt[2] = '{mode: 2'b01, lk: 1, key: FIPS_KEY, blk: FIPS_CT, exp: FIPS_PT};
    vt[3] = '{mode: 2'b00, lk: 0, key: '0,       blk: FIPS_PT, exp: FIPS_CT};

    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      run_txn($sformatf("vec%0d", v), vt[v].mode, vt[v].lk, vt[v].key, vt[v].blk, vt[v].exp, 0, 100, 4);
      if (vt[v].lk) ref_key = vt[v].key;
    end

    // Reserved mode: flagged error, no transaction starts.
    wr_log.delete();
    send_cmd(2'b10, 1'b1, ok);
    chk("rsv cmd_accept", 32'(ok), 32'd1);
    chk("rsv error", 32'(error), 32'd1);
    hi = 0;
    for (int n = 0; n < 4; n++) begin
      if (busy || !cmd_ready) hi++;
      @(negedge clk);
    end
    chk("rsv busy_cycles", 32'(hi), 32'd0);
    chk("rsv writes", 32'(wr_log.size()), 32'd0);
    chk("rsv error_sticky", 32'(error), 32'd1);

    // Randomized traffic with input gaps and output backpressure.
    for (int t = 0; t < 16; t++) begin
      m   = 2'($urandom_range(1));
      lk  = 1'($urandom_range(1));
      key = {$urandom, $urandom, $urandom, $urandom};
      blk = {$urandom, $urandom, $urandom, $urandom};
      if (lk) ref_key = key;
      run_txn($sformatf("rnd%0d", t), m, lk, key, blk, cipher(m, ref_key, blk), 25, 70,
              int'($urandom_range(1, 15)));
    end

    // Timeout: engine never completes.
    eng_never = 1; cur_mode = 2'b00;
    send_cmd(2'b00, 1'b0, ok);
    for (int i = 0; i < 4; i++) send_word($urandom, 0, ok);
    hi = 0; ov = 0;
    for (int n = 0; n < TIMEOUT + 100 && !error; n++) begin
      if (aes_ctrl[2]) hi++;
      if (out_valid) ov++;
      @(negedge clk);
    end
    chk("tmo error", 32'(error), 32'd1);
    chk("tmo ctrl_high_cycles", 32'(hi), 32'(TIMEOUT + 1));
    chk("tmo ctrl", 32'(aes_ctrl), 32'd0);
    chk("tmo busy", 32'(busy), 32'd0);
    chk("tmo out_valid_cycles", 32'(ov), 32'd0);
    eng_never = 0;
    blk = {$urandom, $urandom, $urandom, $urandom};
    run_txn("after_tmo", 2'b01, 1'b0, '0, blk, cipher(2'b01, ref_key, blk), 0, 100, 2);

    // Reset in the middle of WAIT.
    eng_lat = 60; cur_mode = 2'b00;
    send_cmd(2'b00, 1'b0, ok);
    for (int i = 0; i < 4; i++) send_word($urandom, 0, ok);
    for (int n = 0; n < 20 && !aes_ctrl[2]; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("rst_wait in_wait", 32'(aes_ctrl[2]), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    blk = {$urandom, $urandom, $urandom, $urandom};
    run_txn("after_rst_wait", 2'b00, 1'b0, '0, blk, cipher(2'b00, ref_key, blk), 10, 80, 5);

    // Reset in the middle of DRAIN.
    eng_lat = 2; cur_mode = 2'b01;
    send_cmd(2'b01, 1'b0, ok);
    for (int i = 0; i < 4; i++) send_word($urandom, 0, ok);
    out_ready = 1'b0;
    for (int n = 0; n < 200 && !out_valid; n++) @(negedge clk);
    chk("rst_drain in_drain", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_drain");
    chk("rst_drain out_last", 32'(out_last), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    blk = {$urandom, $urandom, $urandom, $urandom};
    run_txn("after_rst_drain", 2'b01, 1'b0, '0, blk, cipher(2'b01, ref_key, blk), 0, 60, 3);

    chk("write_port_invariants", 32'(viol), 32'd0);
    chk("backpressure_stability", 32'(stab_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
